pkt_frame_builder: RTL and testbench
====================================

Name: pkt_frame_builder

Overview:
- Sits directly downstream of the tuple output queue; consumes one {five-tuple, length} descriptor per packet.
- Builds a complete Ethernet/IPv4/UDP frame (no FCS) as a 64-bit AXI4-Stream toward the MAC TX path.
- Holds a 2-entry descriptor buffer with credit-style ready, so pulsed upstream valids are never dropped.
- Computes the IPv4 header checksum, clamps illegal lengths and counts transmitted packets.

Parameters:
- PKT_TUPLE_WIDTH, 104, tuple bits {src_ip[103:72], dst_ip[71:40], src_port[39:24], dst_port[23:8], proto[7:0]}
- PKT_LEN_WIDTH, 16, frame length in bytes, excluding FCS
- DATA_WIDTH, 64, stream width; only 64 supported
- MIN_PKT_LEN, 60, lower length clamp
- MAX_PKT_LEN, 1514, upper length clamp
- DST_MAC, 48'h00_11_22_33_44_55, Ethernet destination
- SRC_MAC, 48'h00_AA_BB_CC_DD_EE, Ethernet source

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- tuple_in  in  PKT_TUPLE_WIDTH  descriptor tuple
- pkt_len_in  in  PKT_LEN_WIDTH  descriptor length
- tuple_in_vld  in  1  descriptor valid; one-cycle pulse per descriptor
- tuple_in_ready  out  1  permission for upstream to pop one descriptor this cycle
- m_axis_tdata  out  64  frame data; byte 0 in [7:0]
- m_axis_tkeep  out  8  byte enables
- m_axis_tvalid  out  1  stream valid
- m_axis_tlast  out  1  last beat of frame
- m_axis_tready  in  1  stream ready
- pkt_count  out  32  frames completed; wraps
- overflow_err  out  1  sticky; descriptor arrived with buffer full

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. Reset clears all outputs to 0, empties the buffer and forces IDLE.
- Reset mid-frame aborts the frame; tlast is not emitted.
- Descriptor buffer: 2 entries.
  - Every tuple_in_vld is written, independent of ready.
  - Write with occupancy 2 drops the descriptor and sets overflow_err.
- tuple_in_ready is registered: ready(next) = (occupancy_next + ready(now)) < 2. Each ready cycle reserves one slot for a valid arriving up to one cycle later.
- FSM states: IDLE, LOAD, SEND.
- IDLE -> LOAD when buffer non-empty.
- LOAD, 1 cycle:
  - pop head; len = clamp(pkt_len_in, MIN_PKT_LEN, MAX_PKT_LEN).
  - compute IPv4 ones'-complement checksum over 10 header halfwords (checksum field 0).
  - beats = ceil(len/8); beat counter = 0.
- SEND:
  - tvalid=1; beat advances only on tvalid&&tready.
  - tdata/tkeep/tlast held stable while stalled.
  - After the last beat is accepted: go to LOAD if buffer non-empty, else IDLE. No idle cycle is required between frames except the LOAD cycle.
- Frame byte layout, network order, byte offset o:
  - 0-5 DST_MAC; 6-11 SRC_MAC; 12-13 0x0800.
  - 14 0x45; 15 0x00; 16-17 len-14; 18-19 0x0000; 20-21 0x4000; 22 0x40; 23 proto.
  - 24-25 checksum; 26-29 src_ip; 30-33 dst_ip.
  - 34-35 src_port; 36-37 dst_port; 38-39 len-34; 40-41 0x0000.
  - o>=42: payload byte (o-42)[7:0].
- Last beat:
  - tlast=1.
  - tkeep = 0xFF if len%8==0, else (1<<(len%8))-1.
  - Disabled bytes driven 0.
- pkt_count increments on acceptance of each tlast beat.
- Simultaneous write and pop in the same cycle is legal; occupancy is unchanged.

Test Plan:
- Reset values: hold resetn=0 for 3 cycles -> all outputs 0. Release -> tuple_in_ready=1 next cycle; tvalid stays 0 with no input.
- Single frame: len=64, src_ip 0A000001, dst_ip 0A000002, ports 1234/5678, proto 0x11, tready=1.
  - 8 beats; tkeep 0xFF throughout; tlast on beat 7.
  - bytes 16-17 = 0x0032; bytes 38-39 = 0x001E; byte 42 = 0x00.
  - checksum matches the software model; pkt_count=1.
- Clamp: len=10 -> 60-byte frame, 8 beats, last tkeep 0x0F. len=2000 -> 1514 bytes, 190 beats, last tkeep 0x03.
- Backpressure: random m_axis_tready at 50% -> data, tkeep and tlast stable while stalled; byte stream identical to the no-stall run.
- Back-to-back: three descriptors pulsed on consecutive ready cycles -> no overflow_err; three frames; exactly one LOAD cycle (tvalid=0) between frames; pkt_count=3.
- Overflow and reset:
  - Force 3 vld pulses while ready=0 -> overflow_err=1 and stays 1.
  - Assert reset during beat 3 of a frame -> tvalid=0 next cycle; buffer empty; overflow_err=0.

Source files
------------

// File: rtl/pkt_frame_builder.sv
// Builds Ethernet/IPv4/UDP frames (no FCS) on a 64-bit AXI4-Stream from {five-tuple, length}
// descriptors held in a 2-entry buffer with credit-style registered ready.
module pkt_frame_builder #(
  parameter int unsigned PKT_TUPLE_WIDTH = 104,
  parameter int unsigned PKT_LEN_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MIN_PKT_LEN     = 60,
  parameter int unsigned MAX_PKT_LEN     = 1514,
  parameter logic [47:0] DST_MAC         = 48'h00_11_22_33_44_55,
  parameter logic [47:0] SRC_MAC         = 48'h00_AA_BB_CC_DD_EE
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [PKT_TUPLE_WIDTH-1:0] tuple_in,
  input  logic [PKT_LEN_WIDTH-1:0]   pkt_len_in,
  input  logic                       tuple_in_vld,
  output logic                       tuple_in_ready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [31:0]                pkt_count,
  output logic                       overflow_err
);

  localparam int unsigned NumLanes = DATA_WIDTH / 8;
  localparam int unsigned LenW     = PKT_LEN_WIDTH;
  localparam int unsigned OffW     = LenW + 3;
  localparam logic [LenW-1:0] MinLen = LenW'(MIN_PKT_LEN);
  localparam logic [LenW-1:0] MaxLen = LenW'(MAX_PKT_LEN);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StSend = 2'd2;

  logic [1:0] state_q, state_d;

  // Descriptor buffer
  logic [PKT_TUPLE_WIDTH-1:0] buf_tuple_q [2];
  logic [LenW-1:0]            buf_len_q   [2];
  logic                       wr_ptr_q, rd_ptr_q;
  logic [1:0]                 occ_q, occ_d;
  logic                       ready_q, ready_d;
  logic                       overflow_q;
  logic                       pop, wr_en;

  assign pop   = (state_q == StLoad);
  // A pop in the same cycle frees a slot, so a write into a full buffer is only lost without one.
  assign wr_en = tuple_in_vld && ((occ_q != 2'd2) || pop);

  always_comb begin
    occ_d = occ_q;
    if (wr_en && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!wr_en && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // Each ready cycle reserves a slot for a valid that may land one cycle later.
  assign ready_d = ({1'b0, occ_d} + {2'b00, ready_q}) < 3'd2;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q   <= occ_d;
      ready_q <= ready_d;
      if (tuple_in_vld && !wr_en) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_tuple_q[wr_ptr_q] <= tuple_in;
      buf_len_q[wr_ptr_q]   <= pkt_len_in;
    end
  end

  // Descriptor load: clamp and header checksum
  logic [PKT_TUPLE_WIDTH-1:0] head_tuple;
  logic [LenW-1:0]            head_len, clamp_len;
  logic [15:0]                load_ip_len;
  logic [19:0]                csum_sum;
  logic [16:0]                csum_fold1;
  logic [15:0]                csum_fold2;
  logic [15:0]                load_csum;

  assign head_tuple = buf_tuple_q[rd_ptr_q];
  assign head_len   = buf_len_q[rd_ptr_q];

  always_comb begin
    clamp_len = head_len;
    if (head_len < MinLen) begin
      clamp_len = MinLen;
    end else if (head_len > MaxLen) begin
      clamp_len = MaxLen;
    end
  end

  assign load_ip_len = 16'(clamp_len - LenW'(14));

  // Zero-valued header halfwords (id, checksum field) are left out of the sum.
  always_comb begin
    csum_sum = 20'h04500
             + {4'h0, load_ip_len}
             + 20'h04000
             + {4'h0, 8'h40, head_tuple[7:0]}
             + {4'h0, head_tuple[103:88]}
             + {4'h0, head_tuple[87:72]}
             + {4'h0, head_tuple[71:56]}
             + {4'h0, head_tuple[55:40]};
    csum_fold1 = {1'b0, csum_sum[15:0]} + {13'b0, csum_sum[19:16]};
    csum_fold2 = csum_fold1[15:0] + {15'b0, csum_fold1[16]};
  end

  assign load_csum = ~csum_fold2;

  // Current frame context
  logic [PKT_TUPLE_WIDTH-1:0] cur_tuple_q;
  logic [LenW-1:0]            cur_len_q;
  logic [15:0]                cur_csum_q;
  logic [LenW-1:0]            beat_q, last_beat_q;
  logic [31:0]                pkt_count_q;
  logic                       send, accept, is_last;

  assign send    = (state_q == StSend);
  assign is_last = (beat_q == last_beat_q);
  assign accept  = send && m_axis_tready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (occ_q != 2'd0) state_d = StLoad;
      StLoad: state_d = StSend;
      StSend: begin
        if (accept && is_last) begin
          state_d = (occ_d != 2'd0) ? StLoad : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cur_tuple_q <= '0;
      cur_len_q   <= '0;
      cur_csum_q  <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        cur_tuple_q <= head_tuple;
        cur_len_q   <= clamp_len;
        cur_csum_q  <= load_csum;
        beat_q      <= '0;
        last_beat_q <= (clamp_len - LenW'(1)) >> 3;
      end else if (accept && !is_last) begin
        beat_q <= beat_q + LenW'(1);
      end
      if (accept && is_last) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
    end
  end

  // Frame header bytes in network order; entries past offset 41 are never selected.
  logic [7:0]  hdr [64];
  logic [15:0] ip_len, udp_len;

  assign ip_len  = 16'(cur_len_q - LenW'(14));
  assign udp_len = 16'(cur_len_q - LenW'(34));

  always_comb begin
    for (int k = 0; k < 64; k++) begin
      hdr[k] = 8'h00;
    end
    for (int k = 0; k < 6; k++) begin
      hdr[k]     = DST_MAC[8*(5-k) +: 8];
      hdr[k + 6] = SRC_MAC[8*(5-k) +: 8];
    end
    hdr[12] = 8'h08;
    hdr[14] = 8'h45;
    hdr[16] = ip_len[15:8];
    hdr[17] = ip_len[7:0];
    hdr[20] = 8'h40;
    hdr[22] = 8'h40;
    hdr[23] = cur_tuple_q[7:0];
    hdr[24] = cur_csum_q[15:8];
    hdr[25] = cur_csum_q[7:0];
    for (int k = 0; k < 4; k++) begin
      hdr[26 + k] = cur_tuple_q[96 - 8*k +: 8];
      hdr[30 + k] = cur_tuple_q[64 - 8*k +: 8];
    end
    hdr[34] = cur_tuple_q[39:32];
    hdr[35] = cur_tuple_q[31:24];
    hdr[36] = cur_tuple_q[23:16];
    hdr[37] = cur_tuple_q[15:8];
    hdr[38] = udp_len[15:8];
    hdr[39] = udp_len[7:0];
  end

  // Output lanes are a pure function of registered state, so they hold while stalled.
  logic [OffW-1:0] lane_off;
  logic [7:0]      lane_byte;
  logic            lane_en;

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    lane_off     = '0;
    lane_byte    = '0;
    lane_en      = 1'b0;
    for (int i = 0; i < NumLanes; i++) begin
      lane_off  = {beat_q, 3'(i)};
      lane_en   = send && (lane_off < {3'b000, cur_len_q});
      lane_byte = (lane_off < OffW'(42)) ? hdr[lane_off[5:0]] : (lane_off[7:0] - 8'd42);
      m_axis_tdata[8*i +: 8] = lane_en ? lane_byte : 8'h00;
      m_axis_tkeep[i]        = lane_en;
    end
  end

  assign m_axis_tvalid  = send;
  assign m_axis_tlast   = send && is_last;
  assign tuple_in_ready = ready_q;
  assign pkt_count      = pkt_count_q;
  assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_pkt_frame_builder.sv
// Directed self-checking bench for pkt_frame_builder: reset, framing, clamps, stalls,
// back-to-back frames, overflow and mid-frame reset.
module tb_pkt_frame_builder;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [103:0] tuple_in = '0;
  logic [15:0]  pkt_len_in = '0;
  logic         tuple_in_vld = 1'b0;
  logic         tuple_in_ready;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b0;
  logic [31:0]  pkt_count;
  logic         overflow_err;

  pkt_frame_builder dut (
    .clk            (clk),
    .resetn         (resetn),
    .tuple_in       (tuple_in),
    .pkt_len_in     (pkt_len_in),
    .tuple_in_vld   (tuple_in_vld),
    .tuple_in_ready (tuple_in_ready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .pkt_count      (pkt_count),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [103:0] T1 = {32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h11};
  localparam logic [103:0] T2 = {32'hC0A80001, 32'hC0A800FE, 16'h1F90, 16'h0035, 8'h11};
  localparam logic [103:0] T3 = {32'hAC100A0B, 32'h08080808, 16'hABCD, 16'h0101, 8'h06};

  // Captured frame
  logic [7:0]  rx_bytes [0:2047];
  logic [7:0]  rx_keep  [0:255];
  int          rx_beats, rx_len, rx_gap, rx_stall_bad, rx_dis_bad;
  bit          rx_timeout;

  function automatic logic [15:0] ip_csum(input logic [103:0] t, input int len);
    logic [15:0] hw [10];
    int s;
    hw[0] = 16'h4500; hw[1] = 16'(len - 14); hw[2] = 16'h0000; hw[3] = 16'h4000;
    hw[4] = {8'h40, t[7:0]}; hw[5] = 16'h0000;
    hw[6] = t[103:88]; hw[7] = t[87:72]; hw[8] = t[71:56]; hw[9] = t[55:40];
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(hw[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return ~16'(s);
  endfunction

  function automatic logic [7:0] exp_byte(input int o, input logic [103:0] t, input int len);
    logic [47:0] dm, sm;
    logic [15:0] ipl, udl, cs;
    dm  = 48'h001122334455;
    sm  = 48'h00AABBCCDDEE;
    ipl = 16'(len - 14);
    udl = 16'(len - 34);
    cs  = ip_csum(t, len);
    if (o < 6)  return dm[8*(5-o) +: 8];
    if (o < 12) return sm[8*(11-o) +: 8];
    if (o >= 26 && o < 30) return t[96 - 8*(o-26) +: 8];
    if (o >= 30 && o < 34) return t[64 - 8*(o-30) +: 8];
    if (o >= 42) return 8'(o - 42);
    case (o)
      12: return 8'h08;
      14: return 8'h45;
      16: return ipl[15:8];
      17: return ipl[7:0];
      20: return 8'h40;
      22: return 8'h40;
      23: return t[7:0];
      24: return cs[15:8];
      25: return cs[7:0];
      34: return t[39:32];
      35: return t[31:24];
      36: return t[23:16];
      37: return t[15:8];
      38: return udl[15:8];
      39: return udl[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    tuple_in_vld = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_desc(input logic [103:0] t, input logic [15:0] l, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tuple_in_ready) begin
        tuple_in = t;
        pkt_len_in = l;
        tuple_in_vld = 1'b1;
        @(negedge clk);
        tuple_in_vld = 1'b0;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns at the negedge where the tlast beat is presented with tready high.
  task automatic recv_frame(input bit rnd, input int max_cycles);
    bit started, stalled, done;
    logic [72:0] held;
    rx_beats = 0; rx_len = 0; rx_gap = 0; rx_stall_bad = 0; rx_dis_bad = 0;
    started = 0; stalled = 0; done = 0; held = '0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!m_axis_tvalid) begin
        if (!started) rx_gap++;
        if (stalled) rx_stall_bad++;
        stalled = 0;
      end else begin
        started = 1;
        if (stalled && ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== held)) rx_stall_bad++;
        if (m_axis_tready) begin
          for (int i = 0; i < 8; i++) begin
            if (m_axis_tkeep[i]) begin
              rx_bytes[rx_len] = m_axis_tdata[8*i +: 8];
              rx_len++;
            end else if (m_axis_tdata[8*i +: 8] !== 8'h00) begin
              rx_dis_bad++;
            end
          end
          rx_keep[rx_beats] = m_axis_tkeep;
          rx_beats++;
          stalled = 0;
          if (m_axis_tlast) done = 1;
        end else begin
          stalled = 1;
          held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end
      end
    end
    rx_timeout = !done;
  endtask

  task automatic test_reset();
    int hi;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast} !== 74'd0) begin
      n_fail++;
      $display("FAIL reset_stream: got %h/%h/%b/%b, want all 0",
               m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast);
    end
    n_tests++;
    if ({tuple_in_ready, pkt_count, overflow_err} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b count=%0d ovf=%b, want 0/0/0",
               tuple_in_ready, pkt_count, overflow_err);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (tuple_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, want 1", tuple_in_ready);
    end
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_axis_tvalid !== 1'b0) hi++;
    end
    n_tests++;
    if (hi !== 0) begin
      n_fail++;
      $display("FAIL reset_idle_tvalid: %0d valid cycles, want 0", hi);
    end
  endtask

  task automatic test_single();
    bit ok;
    int mism, badkeep;
    do_reset();
    send_desc(T1, 16'd64, ok);
    recv_frame(1'b0, 200);
    n_tests++;
    if (!ok || rx_timeout) begin
      n_fail++;
      $display("FAIL single_handshake: desc_ok=%b timeout=%b, want 1/0", ok, rx_timeout);
    end
    n_tests++;
    if (rx_beats !== 8 || rx_len !== 64) begin
      n_fail++;
      $display("FAIL single_beats: beats=%0d bytes=%0d, want 8/64", rx_beats, rx_len);
    end
    badkeep = 0;
    for (int b = 0; b < rx_beats; b++) if (rx_keep[b] !== 8'hFF) badkeep++;
    n_tests++;
    if (badkeep !== 0) begin
      n_fail++;
      $display("FAIL single_tkeep: %0d beats not 0xFF, want 0", badkeep);
    end
    n_tests++;
    if ({rx_bytes[16], rx_bytes[17], rx_bytes[38], rx_bytes[39], rx_bytes[42]} !== 40'h0032_001E_00) begin
      n_fail++;
      $display("FAIL single_lengths: ip=%h%h udp=%h%h b42=%h, want 0032 001e 00",
               rx_bytes[16], rx_bytes[17], rx_bytes[38], rx_bytes[39], rx_bytes[42]);
    end
    n_tests++;
    if ({rx_bytes[24], rx_bytes[25]} !== 16'h26B9 || {rx_bytes[24], rx_bytes[25]} !== ip_csum(T1, 64)) begin
      n_fail++;
      $display("FAIL single_csum: got %h%h, want 26b9 (model %h)",
               rx_bytes[24], rx_bytes[25], ip_csum(T1, 64));
    end
    mism = 0;
    for (int o = 0; o < 64; o++) if (rx_bytes[o] !== exp_byte(o, T1, 64)) mism++;
    n_tests++;
    if (mism !== 0) begin
      n_fail++;
      $display("FAIL single_bytes: %0d byte mismatches, want 0", mism);
    end
    @(negedge clk);
    n_tests++;
    if (pkt_count !== 32'd1) begin
      n_fail++;
      $display("FAIL single_count: got %0d, want 1", pkt_count);
    end
  endtask

  task automatic test_clamp();
    bit ok;
    int mism;
    do_reset();
    send_desc(T2, 16'd10, ok);
    recv_frame(1'b0, 200);
    n_tests++;
    if (!ok || rx_timeout || rx_beats !== 8 || rx_len !== 60 || rx_keep[7] !== 8'h0F) begin
      n_fail++;
      $display("FAIL clamp_min: ok=%b to=%b beats=%0d bytes=%0d keep=%h, want 1/0/8/60/0f",
               ok, rx_timeout, rx_beats, rx_len, rx_keep[7]);
    end
    mism = 0;
    for (int o = 0; o < 60; o++) if (rx_bytes[o] !== exp_byte(o, T2, 60)) mism++;
    n_tests++;
    if (mism !== 0 || rx_dis_bad !== 0 || {rx_bytes[16], rx_bytes[17]} !== 16'h002E) begin
      n_fail++;
      $display("FAIL clamp_min_bytes: mism=%0d dis_nonzero=%0d iplen=%h%h, want 0/0/002e",
               mism, rx_dis_bad, rx_bytes[16], rx_bytes[17]);
    end
    send_desc(T3, 16'd2000, ok);
    recv_frame(1'b0, 600);
    n_tests++;
    if (!ok || rx_timeout || rx_beats !== 190 || rx_len !== 1514 || rx_keep[189] !== 8'h03) begin
      n_fail++;
      $display("FAIL clamp_max: ok=%b to=%b beats=%0d bytes=%0d keep=%h, want 1/0/190/1514/03",
               ok, rx_timeout, rx_beats, rx_len, rx_keep[189]);
    end
    mism = 0;
    for (int o = 0; o < 1514; o++) if (rx_bytes[o] !== exp_byte(o, T3, 1514)) mism++;
    n_tests++;
    if (mism !== 0 || rx_dis_bad !== 0 || {rx_bytes[16], rx_bytes[17]} !== 16'h05DC) begin
      n_fail++;
      $display("FAIL clamp_max_bytes: mism=%0d dis_nonzero=%0d iplen=%h%h, want 0/0/05dc",
               mism, rx_dis_bad, rx_bytes[16], rx_bytes[17]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int mism;
    do_reset();
    send_desc(T1, 16'd100, ok);
    recv_frame(1'b1, 2000);
    n_tests++;
    if (!ok || rx_timeout || rx_beats !== 13 || rx_keep[12] !== 8'h0F) begin
      n_fail++;
      $display("FAIL bp_frame: ok=%b to=%b beats=%0d keep=%h, want 1/0/13/0f",
               ok, rx_timeout, rx_beats, rx_keep[12]);
    end
    n_tests++;
    if (rx_stall_bad !== 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d stalled beats changed, want 0", rx_stall_bad);
    end
    mism = 0;
    for (int o = 0; o < 100; o++) if (rx_bytes[o] !== exp_byte(o, T1, 100)) mism++;
    n_tests++;
    if (mism !== 0) begin
      n_fail++;
      $display("FAIL bp_bytes: %0d byte mismatches, want 0", mism);
    end
  endtask

  task automatic test_back_to_back();
    logic [103:0] tt [3];
    bit ok [3];
    int beats [3], gap [3], mism [3];
    bit to [3];
    tt[0] = T1; tt[1] = T2; tt[2] = T3;
    do_reset();
    fork
      begin
        for (int k = 0; k < 3; k++) send_desc(tt[k], 16'd64, ok[k]);
      end
      begin
        for (int f = 0; f < 3; f++) begin
          recv_frame(1'b0, 300);
          beats[f] = rx_beats;
          gap[f] = rx_gap;
          to[f] = rx_timeout;
          mism[f] = 0;
          for (int o = 0; o < 64; o++) if (rx_bytes[o] !== exp_byte(o, tt[f], 64)) mism[f]++;
        end
      end
    join
    n_tests++;
    if (!(ok[0] && ok[1] && ok[2]) || overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: ok=%b%b%b ovf=%b, want 111/0", ok[0], ok[1], ok[2], overflow_err);
    end
    for (int f = 0; f < 3; f++) begin
      n_tests++;
      if (to[f] || beats[f] !== 8 || mism[f] !== 0) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: to=%b beats=%0d mism=%0d, want 0/8/0", f, to[f], beats[f], mism[f]);
      end
    end
    n_tests++;
    if (gap[1] !== 1 || gap[2] !== 1) begin
      n_fail++;
      $display("FAIL b2b_gap: gaps=%0d/%0d, want 1/1", gap[1], gap[2]);
    end
    @(negedge clk);
    n_tests++;
    if (pkt_count !== 32'd3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d, want 3", pkt_count);
    end
  endtask

  task automatic test_overflow_reset();
    bit ok, seen, hit;
    int accepted, hi;
    do_reset();
    send_desc(T1, 16'd64, ok);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) seen = 1;
    end
    n_tests++;
    if (!ok || !seen) begin
      n_fail++;
      $display("FAIL ovf_setup: ok=%b tvalid_seen=%b, want 1/1", ok, seen);
    end
    tuple_in = T2;
    pkt_len_in = 16'd64;
    tuple_in_vld = 1'b1;
    repeat (3) @(negedge clk);
    tuple_in_vld = 1'b0;
    n_tests++;
    if (overflow_err !== 1'b1 || tuple_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b ready=%b, want 1/0", overflow_err, tuple_in_ready);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b, want 1", overflow_err);
    end
    accepted = 0;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (c != 0) @(negedge clk);
      m_axis_tready = 1'b1;
      if (m_axis_tvalid) begin
        if (accepted == 3) begin
          resetn = 1'b0;
          hit = 1;
        end else begin
          accepted++;
        end
      end
    end
    @(negedge clk);
    n_tests++;
    if (!hit || m_axis_tvalid !== 1'b0 || overflow_err !== 1'b0 || pkt_count !== 32'd0) begin
      n_fail++;
      $display("FAIL midframe_reset: hit=%b tvalid=%b ovf=%b count=%0d, want 1/0/0/0",
               hit, m_axis_tvalid, overflow_err, pkt_count);
    end
    resetn = 1'b1;
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_axis_tvalid !== 1'b0) hi++;
    end
    n_tests++;
    if (hi !== 0 || tuple_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flush: valid_cycles=%0d ready=%b, want 0/1", hi, tuple_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clamp();
    test_backpressure();
    test_back_to_back();
    test_overflow_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
